// File: rtl/dual_source_load_ctrl.sv
// Registered NCH x DW channel bank written from two valid/ready sources (A = host, B = internal bus).
// Latency: a grant in cycle N updates the channel and output register at the next edge (1 cycle).
// Backpressure: one-deep output stream; a grant needs an empty output register or o_ready this cycle.
// Optional even-parity storage per channel is enabled by defining LOAD_PARITY_EN.
module dual_source_load_ctrl #(
    parameter int DW     = 16,
    parameter int NCH    = 4,
    parameter int CW     = 2,
    parameter int STARVE = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inh,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [CW-1:0] a_ch,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [CW-1:0] b_ch,
    input  logic [DW-1:0] b_data,
    input  logic [CW-1:0] rd_ch,
    output logic [DW-1:0] rd_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [CW-1:0] o_ch,
    output logic [DW-1:0] o_data,
    output logic          o_src,
    output logic          busy
`ifdef LOAD_PARITY_EN
    ,
    input  logic          par_err_inj,
    output logic          rd_par,
    output logic          o_par
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0]    STARVE_L = 4'(STARVE);
    localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_flush_idx;
    logic [3:0]      r_starve;
    logic [DW-1:0]   r_ch [NCH];

    logic            w_out_free;
    logic            w_can_grant;
    logic            w_force_b;
    logic            w_grant;
    logic            w_clr_take;
    logic [CW-1:0]   w_wr_ch;
    logic [DW-1:0]   w_wr_dat;

    // Arbitration, readies and next-state decode
    always_comb begin
        w_next_state = r_state;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        busy         = 1'b0;
        w_clr_take   = 1'b0;
        w_out_free   = (r_state == ST_IDLE) || o_ready;
        w_can_grant  = (r_state != ST_FLUSH) && !inh && !clr && w_out_free;
        w_force_b    = b_valid && (r_starve == STARVE_L);

        a_ready = w_can_grant && a_valid && !w_force_b;
        b_ready = w_can_grant && b_valid && !a_ready;
        w_grant = a_ready || b_ready;

        case (r_state)
            ST_FLUSH: begin
                busy = 1'b1;
                if (r_flush_idx == LAST_CH) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                if (clr) begin
                    w_clr_take   = 1'b1;
                    w_next_state = ST_FLUSH;
                end else if (w_grant) begin
                    w_next_state = ST_XFER;
                end else if ((r_state == ST_XFER) && o_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
        endcase
    end

    // Write mux: B only ever carries the write when it holds the ready
    assign w_wr_ch  = b_ready ? b_ch   : a_ch;
    assign w_wr_dat = b_ready ? b_data : a_data;
    assign rd_data  = r_ch[rd_ch];

    // State register and flush index walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_clr_take) begin
                r_flush_idx <= '0;
            end else if (r_state == ST_FLUSH) begin
                r_flush_idx <= r_flush_idx + 1'b1;
            end
        end
    end

    // Channel bank: flush zeroes one entry per cycle, otherwise a grant writes one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_ch[i] <= '0;
            end
        end else if (r_state == ST_FLUSH) begin
            r_ch[r_flush_idx] <= '0;
        end else if (w_grant) begin
            r_ch[w_wr_ch] <= w_wr_dat;
        end
    end

    // One-deep output register; clear drops any pending entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_ch    <= '0;
            o_data  <= '0;
            o_src   <= 1'b0;
        end else if (w_clr_take) begin
            o_valid <= 1'b0;
        end else if (w_grant) begin
            o_valid <= 1'b1;
            o_ch    <= w_wr_ch;
            o_data  <= w_wr_dat;
            o_src   <= b_ready;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

    // Starvation counter: consecutive A wins while B waits, saturating at STARVE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_clr_take) begin
            r_starve <= '0;
        end else if (inh) begin
            r_starve <= r_starve;
        end else if (b_ready || !b_valid) begin
            r_starve <= '0;
        end else if (a_ready && (r_starve != STARVE_L)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

`ifdef LOAD_PARITY_EN
    logic r_par [NCH];
    logic r_o_par;

    assign rd_par = r_par[rd_ch];
    assign o_par  = r_o_par;

    // Even-parity bit per channel, optionally corrupted for error-path testing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_par[i] <= 1'b0;
            end
            r_o_par <= 1'b0;
        end else if (r_state == ST_FLUSH) begin
            r_par[r_flush_idx] <= 1'b0;
        end else if (w_grant && !clr) begin
            r_par[w_wr_ch] <= (^w_wr_dat) ^ par_err_inj;
            r_o_par        <= (^w_wr_dat) ^ par_err_inj;
        end
    end
`endif

endmodule
